// File: rtl/hold_seq_param.sv
// Gate/burst sequencer: holds gate high for a programmable run length, flags the end, optionally re-arms.
// Latency: start sampled in cycle c -> gate high in cycles c+1 .. c+len_q; all outputs registered.
// Backpressure: none; stop is a level abort/cancel honoured every cycle, start only in IDLE.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - burst request (IDLE only)
//   stop        - abort a burst / cancel auto-repeat (any state)
//   len         - burst length, 0 treated as 1, captured on RUN entry
//   auto_rpt    - re-arm after LAST (through GAP when GAP_CYC > 0)
//   gate        - high during RUN cycles
//   done_tgl    - toggles on each LAST entry
//   done        - one-cycle pulse during LAST
//   aborted     - set when LAST was entered via stop, cleared on RUN entry
//   busy        - high whenever not IDLE
//   cnt         - cycles elapsed in the current burst
module hold_seq_param #(
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] len,
    input  logic             auto_rpt,
    output logic             gate,
    output logic             done_tgl,
    output logic             done,
    output logic             aborted,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Gap counter is sized for GAP_CYC but kept at least one bit wide so the
    // design still elaborates when GAP_CYC is 0 (GAP is then unreachable).
    localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] len_q;
    logic [GW-1:0]    gap_q;

    logic load;       // entering RUN: capture len, clear cnt and aborted
    logic cnt_inc;
    logic set_abort;
    logic gap_clr;
    logic gap_inc;

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        cnt_inc   = 1'b0;
        set_abort = 1'b0;
        gap_clr   = 1'b0;
        gap_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                // stop wins over the terminal count so a coincident abort is reported
                if (stop) begin
                    state_d   = S_LAST;
                    set_abort = 1'b1;
                end else if (cnt == len_q - CNT_W'(1)) begin
                    state_d = S_LAST;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_LAST: begin
                if (auto_rpt && !stop) begin
                    if (GAP_CYC > 0) begin
                        state_d = S_GAP;
                        gap_clr = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        load    = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one moves on the
    // same edge as the state it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt      <= '0;
            gap_q    <= '0;
            gate     <= 1'b0;
            done     <= 1'b0;
            done_tgl <= 1'b0;
            aborted  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q <= state_d;
            gate    <= (state_d == S_RUN);
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_LAST);
            // LAST never persists, so a next state of LAST is always an entry
            if (state_d == S_LAST) begin
                done_tgl <= ~done_tgl;
            end
            if (load) begin
                len_q   <= (len == '0) ? CNT_W'(1) : len;
                cnt     <= '0;
                aborted <= 1'b0;
            end else begin
                if (cnt_inc) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (set_abort) begin
                    aborted <= 1'b1;
                end
            end
            if (gap_clr) begin
                gap_q <= '0;
            end else if (gap_inc) begin
                gap_q <= gap_q + GW'(1);
            end
        end
    end

endmodule
